// File: rtl/slow_memory_mc.sv
// slow_memory_mc: shared line memory serving NCH round-robin channels with fixed access latency
module slow_memory_mc #(
  parameter int NCH     = 2,
  parameter int LINE_W  = 128,
  parameter int ADDR_W  = 28,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH-1:0]        mem_read,
  input  logic [NCH-1:0]        mem_write,
  input  logic [NCH*ADDR_W-1:0] mem_addr,
  input  logic [NCH*LINE_W-1:0] mem_wdata,
  output logic [NCH*LINE_W-1:0] mem_rdata,
  output logic [NCH-1:0]        mem_ready,
  output logic                  busy,
  output logic                  err_oob,
  output logic                  err_rw
);
  localparam int CW  = NCH > 1 ? $clog2(NCH) : 1;
  localparam int AW  = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CNW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t              r_state, w_next;
  logic [CW-1:0]       r_rr, r_gnt, w_sel;
  logic                r_wr, r_oob;
  logic [ADDR_W-1:0]   r_addr;
  logic [LINE_W-1:0]   r_wdata;
  logic [CNW-1:0]      r_cnt;
  logic [NCH*LINE_W-1:0] r_rdata;
  logic                r_err_oob, r_err_rw;
  logic [LINE_W-1:0]   r_mem [DEPTH];
  logic [NCH-1:0]      w_req;
  logic                w_any, w_req_g, w_fire, w_grant, w_oob;
  logic [ADDR_W-1:0]   w_addr;

  assign w_req   = mem_read | mem_write;
  assign w_req_g = w_req[r_gnt];
  assign w_grant = (r_state == S_IDLE) && w_any;
  assign w_fire  = (r_state == S_BUSY) && w_req_g && (r_cnt == '0);
  assign w_addr  = mem_addr[w_sel*ADDR_W +: ADDR_W];
  assign w_oob   = 64'(w_addr) >= 64'(DEPTH);

  assign mem_rdata = r_rdata;
  assign mem_ready = (r_state == S_RESP) ? (NCH'(1) << r_gnt) : '0;
  assign busy      = r_state != S_IDLE;
  assign err_oob   = r_err_oob;
  assign err_rw    = r_err_rw;

  // Round-robin pick: first requester at or after the rr pointer, wrapping.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      automatic int j = (int'(r_rr) + i) % NCH;
      if (!w_any && w_req[j]) begin
        w_any = 1'b1;
        w_sel = CW'(j);
      end
    end
  end

  // FSM next state; a dropped request in BUSY aborts the access.
  always_comb begin
    w_next = r_state;
    w_next = (r_state == S_IDLE) ? (w_any ? S_BUSY : S_IDLE) :
             (r_state == S_BUSY) ? (!w_req_g ? S_IDLE : (r_cnt == '0 ? S_RESP : S_BUSY)) :
             S_IDLE;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Grant latching, latency counter, read return, rr advance and sticky errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr      <= '0;
      r_gnt     <= '0;
      r_wr      <= 1'b0;
      r_oob     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_cnt     <= '0;
      r_rdata   <= '0;
      r_err_oob <= 1'b0;
      r_err_rw  <= 1'b0;
    end else begin
      if (w_grant) begin
        r_gnt     <= w_sel;
        r_wr      <= mem_write[w_sel];
        r_addr    <= w_addr;
        r_wdata   <= mem_wdata[w_sel*LINE_W +: LINE_W];
        r_oob     <= w_oob;
        r_cnt     <= CNW'(LATENCY - 1);
        r_err_oob <= r_err_oob | w_oob;
        r_err_rw  <= r_err_rw | (mem_read[w_sel] & mem_write[w_sel]);
      end
      if (r_state == S_BUSY && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      if (w_fire && !r_wr) r_rdata[r_gnt*LINE_W +: LINE_W] <= r_oob ? '0 : r_mem[r_addr[AW-1:0]];
      if (r_state == S_RESP) r_rr <= (r_gnt == CW'(NCH - 1)) ? '0 : r_gnt + 1'b1;
    end
  end

  // Line array is never reset so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_fire && r_wr && !r_oob) r_mem[r_addr[AW-1:0]] <= r_wdata;
  end
endmodule

// File: tb/tb_slow_memory_mc.sv
// tb_slow_memory_mc: directed checks of grant, latency, abort, error and reset behaviour
module tb_slow_memory_mc;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   mem_read, mem_write;
  logic [55:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic [1:0]   mem_ready;
  logic         busy, err_oob, err_rw;
  int n_chk = 0, n_fail = 0;

  localparam logic [127:0] PA5 = {16{8'hA5}};
  localparam logic [127:0] P5A = {16{8'h5A}};
  localparam logic [127:0] PDB = {4{32'hDEADBEEF}};
  localparam logic [127:0] PX7 = {4{32'h0123_4567}};
  localparam logic [127:0] PV9 = {4{32'h9999_0009}};
  localparam logic [127:0] PW9 = {4{32'hBAD0_BAD0}};

  slow_memory_mc dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .busy(busy), .err_oob(err_oob), .err_rw(err_rw)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic acc(input int ch, input logic rd, input logic wr, input logic [27:0] a,
                     input logic [127:0] d, output int lat);
    @(negedge clk);
    mem_read[ch] = rd;
    mem_write[ch] = wr;
    mem_addr[ch*28 +: 28] = a;
    mem_wdata[ch*128 +: 128] = d;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!mem_ready[ch] && lat < 100);
    mem_read[ch] = 1'b0;
    mem_write[ch] = 1'b0;
  endtask

  int lat, nr, saw0;
  int rcyc[4];
  logic [1:0] rmask[4];

  initial begin
    rst_n = 1'b0; mem_read = '0; mem_write = '0; mem_addr = '0; mem_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", mem_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", mem_rdata[127:0] | mem_rdata[255:128], 0);
    chk("rst_errs", {err_oob, err_rw}, 0);
    rst_n = 1'b1;
    // 1) preload, then timed reads of lines 5 and 6
    acc(0, 0, 1, 5, PA5, lat);
    acc(0, 0, 1, 6, P5A, lat);
    acc(0, 1, 0, 5, 0, lat);
    chk("t1_lat", lat, 9);
    chk("t1_rd5", mem_rdata[127:0], PA5);
    @(negedge clk);
    chk("t1_pulse", mem_ready, 0);
    chk("t1_hold", mem_rdata[127:0], PA5);
    acc(0, 1, 0, 6, 0, lat);
    chk("t1_rd6", mem_rdata[127:0], P5A);
    // 2) ch1 write, ch0 read-back, ch1 untouched
    acc(1, 1, 0, 5, 0, lat);
    chk("t2_rd1", mem_rdata[255:128], PA5);
    acc(1, 0, 1, 3, PDB, lat);
    chk("t2_wlat", lat, 9);
    acc(0, 1, 0, 3, 0, lat);
    chk("t2_rd0", mem_rdata[127:0], PDB);
    chk("t2_keep1", mem_rdata[255:128], PA5);
    acc(1, 1, 0, 6, 0, lat);
    chk("t2_rd1b", mem_rdata[255:128], P5A);
    // 3) contention: rr pointer now 0, expect 0,1,0,1 spaced 10 cycles
    @(negedge clk);
    mem_addr = {28'd6, 28'd5};
    mem_read = 2'b11;
    nr = 0;
    for (int cyc = 0; cyc < 100 && nr < 4; cyc++) begin
      @(negedge clk);
      if (mem_ready != 2'b00) begin
        rcyc[nr] = cyc;
        rmask[nr] = mem_ready;
        nr++;
        mem_read = (nr < 4) ? (2'b11 & ~mem_ready) : 2'b00;
      end else if (nr < 4) mem_read = 2'b11;
    end
    mem_read = 2'b00;
    chk("t3_count", nr, 4);
    chk("t3_g0", rmask[0], 2'b01);
    chk("t3_g1", rmask[1], 2'b10);
    chk("t3_g2", rmask[2], 2'b01);
    chk("t3_g3", rmask[3], 2'b10);
    for (int i = 0; i < 3; i++) chk("t3_gap", rcyc[i+1] - rcyc[i], 10);
    chk("t3_rd0", mem_rdata[127:0], PA5);
    chk("t3_rd1", mem_rdata[255:128], P5A);
    // 4) ch0 aborts 3 cycles after grant; pending ch1 then served
    @(negedge clk);
    mem_addr = {28'd5, 28'd5};
    mem_read = 2'b01;
    @(negedge clk);
    mem_read = 2'b11;
    @(negedge clk);
    @(negedge clk);
    chk("t4_busy", busy, 1);
    mem_read = 2'b10;
    @(negedge clk);
    chk("t4_idle", busy, 0);
    chk("t4_nordy", mem_ready, 0);
    lat = 0; saw0 = 0;
    do begin
      @(negedge clk);
      lat++;
      saw0 |= int'(mem_ready[0]);
    end while (!mem_ready[1] && lat < 100);
    mem_read = 2'b00;
    chk("t4_lat1", lat, 9);
    chk("t4_saw0", saw0, 0);
    chk("t4_rd1", mem_rdata[255:128], PA5);
    chk("t4_keep0", mem_rdata[127:0], PA5);
    // 5) out-of-range and read+write errors
    chk("t5_pre", {err_oob, err_rw}, 0);
    acc(0, 1, 0, 257, 0, lat);
    chk("t5_oob_lat", lat, 9);
    chk("t5_oob_rd", mem_rdata[127:0], 0);
    chk("t5_oob", err_oob, 1);
    acc(1, 1, 0, 5, 0, lat);
    chk("t5_oob_sticky", err_oob, 1);
    chk("t5_rw_clr", err_rw, 0);
    acc(0, 1, 1, 7, PX7, lat);
    chk("t5_rw", err_rw, 1);
    chk("t5_rw_rdata", mem_rdata[127:0], 0);
    acc(1, 1, 0, 7, 0, lat);
    chk("t5_rw_wrote", mem_rdata[255:128], PX7);
    // 6) reset during a write leaves the line intact
    acc(1, 0, 1, 9, PV9, lat);
    @(negedge clk);
    mem_write[1] = 1'b1; mem_addr[55:28] = 28'd9; mem_wdata[255:128] = PW9;
    repeat (3) @(negedge clk);
    chk("t6_busy", busy, 1);
    rst_n = 1'b0;
    mem_write = 2'b00;
    #1;
    chk("t6_busy0", busy, 0);
    chk("t6_ready0", mem_ready, 0);
    chk("t6_rdata0", mem_rdata[127:0] | mem_rdata[255:128], 0);
    chk("t6_errs0", {err_oob, err_rw}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    acc(0, 1, 0, 9, 0, lat);
    chk("t6_lat", lat, 9);
    chk("t6_keep9", mem_rdata[127:0], PV9);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
